serdes_frame_arbiter: RTL and testbench
=======================================

SERDES_FRAME_ARBITER -- requirements
Module: serdes_frame_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 300: SEND-state cycle limit for the watchdog (9-bit compare, legal range 257..511).
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 REQ  in  4  per-requester frame request, level, held until granted and committed.
REQ-005 GNT  out  4  one-hot grant, zero when no requester owns the load bus.
REQ-006 WR_EN  in  1  load-bus word write strobe from the granted requester.
REQ-007 WR_ADDR  in  3  frame word index, 0..7.
REQ-008 WR_DATA  in  32  frame word data.
REQ-009 COMMIT  in  1  granted requester declares frame complete.
REQ-010 PAR_OUT1..PAR_OUT8  out  32 each  frame buffer words to serializer PAR_IN1..PAR_IN8.
REQ-011 SER_READY  out  1  drives serializer READY.
REQ-012 SER_COMPLETE  in  1  serializer COMPLETE.
REQ-013 DONE  out  1  one-cycle pulse, frame fully serialized.
REQ-014 ERR  out  1  one-cycle pulse, watchdog abort.
REQ-015 OWNER  out  2  index of last granted requester.
REQ-016 FRAME_CNT  out  16  count of DONE pulses, wraps 0xFFFF->0.

Function
REQ-017 FSM states: IDLE, LOAD, SEND, FIN; exactly one active.
REQ-018 IDLE: any REQ bit high -> next cycle GNT one-hot for the winner, OWNER updated, state LOAD.
REQ-019 Arbitration: round-robin, search starts at OWNER+1 mod 4; after reset search starts at 0.
REQ-020 LOAD: WR_EN=1 writes WR_DATA to buffer word WR_ADDR on that edge; WR_EN is ignored in all other states.
REQ-021 LOAD: COMMIT=1 with REQ[OWNER]=1 -> next cycle GNT=0, SER_READY=1, state SEND.
REQ-022 WR_EN and COMMIT in the same cycle: the write is applied and included in the frame.
REQ-023 LOAD: REQ[OWNER] drops without COMMIT -> abort, next cycle GNT=0, state IDLE, buffer contents retained, no DONE.
REQ-024 Words not written during LOAD keep their previous values; PAR_OUTn always reflects the buffer registers directly.
REQ-025 The buffer is frozen while in SEND and FIN.
REQ-026 SEND: SER_READY held 1 until SER_COMPLETE=1 is sampled; next cycle SER_READY=0, DONE=1, FRAME_CNT+1, state FIN.
REQ-027 FIN: one cycle, SER_READY=0 so the serializer self-clears; then IDLE, arbitration resumes.
REQ-028 Commit-to-DONE latency with a compliant serializer: 258 cycles.
REQ-029 SER_COMPLETE outside SEND is ignored.
REQ-030 REQ changes during SEND/FIN have no effect until IDLE.

Reset
REQ-031 RESET=0 asynchronously forces state IDLE, GNT=0, SER_READY=0, DONE=0, ERR=0, OWNER=3, FRAME_CNT=0, all buffer words 0.
REQ-032 Reset mid-SEND drops SER_READY immediately; no DONE or ERR is produced for the aborted frame.

Configuration
REQ-033 Macro SERDES_ARB_WATCHDOG_EN defined: 9-bit counter clears on SEND entry and increments each SEND cycle.
REQ-034 With SERDES_ARB_WATCHDOG_EN, reaching TIMEOUT_CYC without SER_COMPLETE -> next cycle SER_READY=0, ERR=1, FRAME_CNT unchanged, state FIN.
REQ-035 Macro undefined: no counter is built, ERR is tied 0, and SEND waits indefinitely for SER_COMPLETE.

Verification
REQ-036 REQ=4'b0001, write words 0..7 = 0x11111111*(n+1), COMMIT -> GNT=0001 one cycle after REQ; SER_READY high 256 cycles; PAR_OUT1..8 stable; DONE 258 cycles after COMMIT; FRAME_CNT=1.
REQ-037 REQ=4'b1111 held across 4 frames -> grant order 0,1,2,3; FRAME_CNT=4; GNT never multi-hot.
REQ-038 Grant to requester 2; drop REQ[2] after 3 writes with no COMMIT -> IDLE next cycle, no DONE; next grant goes to requester 3.
REQ-039 WR_EN with WR_ADDR=7, data 0xDEADBEEF, and COMMIT in the same cycle -> PAR_OUT8=0xDEADBEEF during SEND.
REQ-040 Watchdog enabled, serializer model never asserts COMPLETE -> ERR pulse at cycle TIMEOUT_CYC+1 of SEND, SER_READY=0, FRAME_CNT unchanged; with the macro undefined -> still in SEND at cycle 1000.
REQ-041 RESET pulse at SEND cycle 100 -> SER_READY=0 asynchronously, buffer=0, FRAME_CNT=0, OWNER=3, first post-reset grant to requester 0.

Source files
------------

// File: rtl/serdes_frame_arbiter.sv
// ---------------------------------------------------------------------------
// serdes_frame_arbiter
//
// Purpose: round-robin arbiter that hands a shared load bus to one of four
// requesters. The granted requester fills an 8-word frame buffer and commits
// it. The buffer is then presented to a parallel-in serializer until the
// serializer reports completion.
//
// Ports:
//   CLK           rising-edge clock for all state
//   RESET         asynchronous, active-low reset
//   REQ[3:0]      per-requester frame request (level)
//   GNT[3:0]      one-hot grant, zero when the load bus is free
//   WR_EN         buffer word write strobe (honoured only while loading)
//   WR_ADDR[2:0]  buffer word index
//   WR_DATA[31:0] buffer word data
//   COMMIT        granted requester declares the frame complete
//   PAR_OUT1..8   buffer words, driven straight from the buffer registers
//   SER_READY     serializer READY
//   SER_COMPLETE  serializer COMPLETE (ignored outside SEND)
//   DONE          one-cycle pulse when a frame has been serialized
//   ERR           one-cycle pulse when the watchdog aborts a frame
//   OWNER[1:0]    index of the last granted requester
//   FRAME_CNT     count of DONE pulses, wraps at 16 bits
//
// Build option: define SERDES_ARB_WATCHDOG_EN to build the SEND watchdog.
// The watchdog aborts a frame after TIMEOUT_CYC cycles in SEND. Without the
// macro, ERR is tied low and SEND waits for SER_COMPLETE indefinitely.
// ---------------------------------------------------------------------------
module serdes_frame_arbiter #(
  parameter int TIMEOUT_CYC = 300
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  REQ,
  output logic [3:0]  GNT,
  input  logic        WR_EN,
  input  logic [2:0]  WR_ADDR,
  input  logic [31:0] WR_DATA,
  input  logic        COMMIT,
  output logic [31:0] PAR_OUT1,
  output logic [31:0] PAR_OUT2,
  output logic [31:0] PAR_OUT3,
  output logic [31:0] PAR_OUT4,
  output logic [31:0] PAR_OUT5,
  output logic [31:0] PAR_OUT6,
  output logic [31:0] PAR_OUT7,
  output logic [31:0] PAR_OUT8,
  output logic        SER_READY,
  input  logic        SER_COMPLETE,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  OWNER,
  output logic [15:0] FRAME_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_FIN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  gnt_reg, gnt_next;
  logic [1:0]  owner_reg, owner_next;
  logic        ser_ready_reg, ser_ready_next;
  logic        done_reg, done_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic [1:0]  rr_winner;
  logic        wr_fire;

  // The watchdog compare is 9 bits wide, so only 257..511 is meaningful.
  if (TIMEOUT_CYC < 257 || TIMEOUT_CYC > 511) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 257..511");
  end

  // Writes land only while the owner is loading; the buffer is frozen
  // in every other state.
  assign wr_fire = (state_reg == ST_LOAD) && WR_EN;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_word
    logic [31:0] word_reg;
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        word_reg <= '0;
      end else if (wr_fire && (WR_ADDR == 3'(gi))) begin
        word_reg <= WR_DATA;
      end
    end
  end

  assign PAR_OUT1 = g_word[0].word_reg;
  assign PAR_OUT2 = g_word[1].word_reg;
  assign PAR_OUT3 = g_word[2].word_reg;
  assign PAR_OUT4 = g_word[3].word_reg;
  assign PAR_OUT5 = g_word[4].word_reg;
  assign PAR_OUT6 = g_word[5].word_reg;
  assign PAR_OUT7 = g_word[6].word_reg;
  assign PAR_OUT8 = g_word[7].word_reg;

  // Round-robin search starting just after the last owner. OWNER resets
  // to 3, so the first search after reset starts at requester 0.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    rr_winner = owner_reg + 2'd1;
    cand      = owner_reg;
    found     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = owner_reg + 2'(i);
      if (!found && REQ[cand]) begin
        rr_winner = cand;
        found     = 1'b1;
      end
    end
  end

`ifdef SERDES_ARB_WATCHDOG_EN
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYC);

  logic [8:0] wd_cnt_reg;
  logic       wd_expired;
  logic       err_reg, err_next;

  // In SEND cycle k the counter holds k-1, so expiry is flagged in cycle
  // TIMEOUT_CYC and ERR appears in cycle TIMEOUT_CYC+1.
  assign wd_expired = (wd_cnt_reg + 9'd1) == TIMEOUT_LIM;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == ST_SEND) ? wd_cnt_reg + 9'd1 : 9'd0;
      err_reg    <= err_next;
    end
  end

  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      owner_reg     <= 2'd3;
      ser_ready_reg <= 1'b0;
      done_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      owner_reg     <= owner_next;
      ser_ready_reg <= ser_ready_next;
      done_reg      <= done_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    owner_next     = owner_reg;
    ser_ready_next = ser_ready_reg;
    done_next      = 1'b0;
    frame_cnt_next = frame_cnt_reg;
`ifdef SERDES_ARB_WATCHDOG_EN
    err_next       = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (|REQ) begin
          gnt_next   = 4'b0001 << rr_winner;
          owner_next = rr_winner;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A dropped request aborts the load even if COMMIT is also high.
        if (!REQ[owner_reg]) begin
          gnt_next   = '0;
          state_next = ST_IDLE;
        end else if (COMMIT) begin
          gnt_next       = '0;
          ser_ready_next = 1'b1;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (SER_COMPLETE) begin
          ser_ready_next = 1'b0;
          done_next      = 1'b1;
          frame_cnt_next = frame_cnt_reg + 16'd1;
          state_next     = ST_FIN;
        end
`ifdef SERDES_ARB_WATCHDOG_EN
        else if (wd_expired) begin
          ser_ready_next = 1'b0;
          err_next       = 1'b1;
          state_next     = ST_FIN;
        end
`endif
      end
      ST_FIN: begin
        // One idle cycle with READY low lets the serializer self-clear.
        ser_ready_next = 1'b0;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign GNT       = gnt_reg;
  assign OWNER     = owner_reg;
  assign SER_READY = ser_ready_reg;
  assign DONE      = done_reg;
  assign FRAME_CNT = frame_cnt_reg;

endmodule

// File: tb/tb_serdes_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serdes_frame_arbiter
//
// Self-checking bench for serdes_frame_arbiter. A serializer model asserts
// COMPLETE after sampling READY for 256 cycles. Committed frames are pushed
// to a scoreboard and compared against the buffer outputs when DONE pulses.
// ---------------------------------------------------------------------------
module tb_serdes_frame_arbiter;

  localparam int TIMEOUT = 300;

  typedef logic [7:0][31:0] words_t;
  typedef struct packed {
    logic [1:0] owner;
    words_t     words;
  } frame_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  REQ = '0;
  logic [3:0]  GNT;
  logic        WR_EN = 1'b0;
  logic [2:0]  WR_ADDR = '0;
  logic [31:0] WR_DATA = '0;
  logic        COMMIT = 1'b0;
  logic [31:0] par [8];
  logic        SER_READY;
  logic        DONE;
  logic        ERR;
  logic [1:0]  OWNER;
  logic [15:0] FRAME_CNT;

  int     errors = 0;
  int     checks = 0;
  words_t model_buf = '0;
  frame_t sb_q[$];
  bit     never_complete = 1'b0;
  bit     expect_err = 1'b0;

  int   ser_cnt;
  logic ser_complete;

  serdes_frame_arbiter #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .COMMIT(COMMIT),
    .PAR_OUT1(par[0]), .PAR_OUT2(par[1]), .PAR_OUT3(par[2]), .PAR_OUT4(par[3]),
    .PAR_OUT5(par[4]), .PAR_OUT6(par[5]), .PAR_OUT7(par[6]), .PAR_OUT8(par[7]),
    .SER_READY(SER_READY), .SER_COMPLETE(ser_complete),
    .DONE(DONE), .ERR(ERR), .OWNER(OWNER), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  // Serializer model: COMPLETE rises after 256 sampled READY cycles and
  // clears once READY drops.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ser_cnt      <= 0;
      ser_complete <= 1'b0;
    end else if (!SER_READY) begin
      ser_cnt      <= 0;
      ser_complete <= 1'b0;
    end else if (ser_cnt >= 255) begin
      if (!never_complete) ser_complete <= 1'b1;
    end else begin
      ser_cnt <= ser_cnt + 1;
    end
  end

  function automatic words_t pack_par();
    words_t w;
    for (int i = 0; i < 8; i++) w[i] = par[i];
    return w;
  endfunction

  // Continuous monitor: grant one-hot, scoreboard on DONE, stray ERR.
  always @(negedge CLK) begin
    if (RESET) begin
      if (GNT != 4'b0000) begin
        checks++;
        if ((GNT & (GNT - 4'd1)) != 4'b0000) begin
          errors++;
          $display("FAIL gnt_onehot: got %b required one-hot", GNT);
        end
      end
      if (DONE) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got DONE=1 required no pending frame");
        end else begin
          frame_t f;
          f = sb_q.pop_front();
          if (pack_par() !== f.words || OWNER !== f.owner) begin
            errors++;
            $display("FAIL scoreboard: got owner=%0d words=%h required owner=%0d words=%h",
                     OWNER, pack_par(), f.owner, f.words);
          end
        end
      end
      if (ERR && !expect_err) begin
        checks++;
        errors++;
        $display("FAIL err_unexpected: got ERR=1 required 0");
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push_frame(input logic [1:0] own);
    frame_t f;
    f.owner = own;
    f.words = model_buf;
    sb_q.push_back(f);
  endtask

  // Request, wait for the grant, write nw words, commit. Returns in SEND
  // cycle 1 with the request changed to req_after.
  task automatic do_frame(input logic [3:0] req, input logic [1:0] exp_owner,
                          input int nw, input logic [31:0] base,
                          input logic [3:0] req_after, output int gw);
    REQ = req;
    gw = 0;
    do begin
      tick();
      gw++;
    end while (GNT == 4'b0000 && gw < 20);
    checks++;
    if (GNT !== (4'b0001 << exp_owner) || OWNER !== exp_owner) begin
      errors++;
      $display("FAIL grant: got gnt=%b owner=%0d required gnt=%b owner=%0d",
               GNT, OWNER, 4'b0001 << exp_owner, exp_owner);
    end
    for (int i = 0; i < nw; i++) begin
      WR_EN = 1'b1;
      WR_ADDR = 3'(i);
      WR_DATA = base * 32'(i + 1);
      model_buf[i] = WR_DATA;
      tick();
    end
    WR_EN = 1'b0;
    COMMIT = 1'b1;
    push_frame(exp_owner);
    tick();
    COMMIT = 1'b0;
    REQ = req_after;
  endtask

  // Wait (bounded) for DONE. lat is the cycle number of DONE counted from
  // the commit cycle; rh counts READY cycles before COMPLETE; chg flags any
  // buffer change while waiting.
  task automatic wait_done(input int start, output int lat, output int rh, output bit chg);
    words_t snap;
    snap = pack_par();
    lat = start;
    rh = 0;
    chg = 1'b0;
    while (lat < start + 3000) begin
      if (SER_READY && !ser_complete) rh++;
      if (pack_par() !== snap) chg = 1'b1;
      if (DONE) break;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    tick();
    tick();
    checks++;
    if (GNT !== 4'b0 || SER_READY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b rdy=%b done=%b err=%b required 0000 0 0 0",
               GNT, SER_READY, DONE, ERR);
    end
    checks++;
    if (OWNER !== 2'd3 || FRAME_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: got owner=%0d cnt=%0d required owner=3 cnt=0", OWNER, FRAME_CNT);
    end
    checks++;
    if (pack_par() !== '0) begin
      errors++;
      $display("FAIL reset_buf: got %h required 0", pack_par());
    end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int gw, lat, rh;
    bit chg;
    do_frame(4'b0001, 2'd0, 8, 32'h11111111, 4'b0000, gw);
    checks++;
    if (gw != 1) begin
      errors++;
      $display("FAIL grant_latency: got %0d required 1", gw);
    end
    wait_done(1, lat, rh, chg);
    checks++;
    if (lat != 258) begin
      errors++;
      $display("FAIL done_latency: got %0d required 258", lat);
    end
    checks++;
    if (rh != 256) begin
      errors++;
      $display("FAIL ready_cycles: got %0d required 256", rh);
    end
    checks++;
    if (chg) begin
      errors++;
      $display("FAIL par_stable: got change during SEND required stable");
    end
    checks++;
    if (par[0] !== 32'h11111111 || par[7] !== 32'h88888888 || FRAME_CNT !== 16'd1) begin
      errors++;
      $display("FAIL single_frame: got w0=%h w7=%h cnt=%0d required 11111111 88888888 1",
               par[0], par[7], FRAME_CNT);
    end
  endtask

  task automatic test_round_robin();
    int gw, lat, rh;
    bit chg;
    RESET = 1'b0;
    REQ = 4'b0000;
    tick();
    RESET = 1'b1;
    sb_q.delete();
    model_buf = '0;
    tick();
    for (int f = 0; f < 4; f++) begin
      do_frame(4'b1111, 2'(f), f + 1, 32'h01000000 * 32'(f + 1),
               (f == 3) ? 4'b0000 : 4'b1111, gw);
      wait_done(1, lat, rh, chg);
      checks++;
      if (lat != 258) begin
        errors++;
        $display("FAIL rr_latency: frame %0d got %0d required 258", f, lat);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd4) begin
      errors++;
      $display("FAIL rr_count: got %0d required 4", FRAME_CNT);
    end
  endtask

  task automatic test_abort();
    tick();
    REQ = 4'b0100;
    tick();
    checks++;
    if (GNT !== 4'b0100 || OWNER !== 2'd2) begin
      errors++;
      $display("FAIL abort_grant: got gnt=%b owner=%0d required 0100 2", GNT, OWNER);
    end
    for (int i = 0; i < 3; i++) begin
      WR_EN = 1'b1;
      WR_ADDR = 3'(i);
      WR_DATA = 32'hA0A0_0000 + 32'(i);
      model_buf[i] = WR_DATA;
      tick();
    end
    WR_EN = 1'b0;
    REQ = 4'b0000;
    tick();
    checks++;
    if (GNT !== 4'b0000 || DONE !== 1'b0 || SER_READY !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got gnt=%b done=%b rdy=%b required 0000 0 0", GNT, DONE, SER_READY);
    end
    checks++;
    if (pack_par() !== model_buf) begin
      errors++;
      $display("FAIL abort_retain: got %h required %h", pack_par(), model_buf);
    end
    REQ = 4'b1100;
    tick();
    checks++;
    if (GNT !== 4'b1000 || OWNER !== 2'd3) begin
      errors++;
      $display("FAIL abort_next: got gnt=%b owner=%0d required 1000 3", GNT, OWNER);
    end
  endtask

  // Continues from test_abort with requester 3 holding the grant.
  task automatic test_write_commit();
    int lat, rh;
    bit chg;
    WR_EN = 1'b1;
    WR_ADDR = 3'd7;
    WR_DATA = 32'hDEADBEEF;
    COMMIT = 1'b1;
    model_buf[7] = 32'hDEADBEEF;
    push_frame(2'd3);
    tick();
    WR_EN = 1'b0;
    COMMIT = 1'b0;
    REQ = 4'b0000;
    checks++;
    if (SER_READY !== 1'b1 || par[7] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_commit: got rdy=%b w7=%h required 1 deadbeef", SER_READY, par[7]);
    end
    wait_done(1, lat, rh, chg);
    checks++;
    if (lat != 258 || chg) begin
      errors++;
      $display("FAIL write_commit_send: got lat=%0d chg=%0d required 258 0", lat, chg);
    end
  endtask

  task automatic test_watchdog();
    int gw, k;
    logic [15:0] fc;
    never_complete = 1'b1;
    fc = FRAME_CNT;
    do_frame(4'b0001, 2'd0, 2, 32'h0BAD0000, 4'b0000, gw);
`ifdef SERDES_ARB_WATCHDOG_EN
    expect_err = 1'b1;
    k = 1;
    while (!ERR && k < 1000) begin
      tick();
      k++;
    end
    checks++;
    if (k != TIMEOUT + 1 || SER_READY !== 1'b0 || FRAME_CNT !== fc) begin
      errors++;
      $display("FAIL watchdog: got cycle=%0d rdy=%b cnt=%0d required %0d 0 %0d",
               k, SER_READY, FRAME_CNT, TIMEOUT + 1, fc);
    end
    void'(sb_q.pop_front());
    tick();
    expect_err = 1'b0;
    never_complete = 1'b0;
`else
    begin
      int lat, rh;
      bit chg;
      k = 1;
      repeat (999) begin
        tick();
        k++;
      end
      checks++;
      if (SER_READY !== 1'b1 || FRAME_CNT !== fc) begin
        errors++;
        $display("FAIL no_watchdog: got rdy=%b cnt=%0d at cycle %0d required 1 %0d",
                 SER_READY, FRAME_CNT, k, fc);
      end
      never_complete = 1'b0;
      wait_done(k, lat, rh, chg);
      checks++;
      if (lat != 1002 || FRAME_CNT !== fc + 16'd1) begin
        errors++;
        $display("FAIL late_complete: got lat=%0d cnt=%0d required 1002 %0d",
                 lat, FRAME_CNT, fc + 16'd1);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_send();
    int gw;
    do_frame(4'b0010, 2'd1, 4, 32'h00C0FFEE, 4'b0000, gw);
    repeat (99) tick();
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (SER_READY !== 1'b0 || GNT !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b gnt=%b required 0 0000", SER_READY, GNT);
    end
    checks++;
    if (pack_par() !== '0 || FRAME_CNT !== 16'd0 || OWNER !== 2'd3) begin
      errors++;
      $display("FAIL reset_state: got buf=%h cnt=%0d owner=%0d required 0 0 3",
               pack_par(), FRAME_CNT, OWNER);
    end
    sb_q.delete();
    model_buf = '0;
    tick();
    RESET = 1'b1;
    REQ = 4'b1111;
    tick();
    checks++;
    if (GNT !== 4'b0001 || OWNER !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_grant: got gnt=%b owner=%0d required 0001 0", GNT, OWNER);
    end
    REQ = 4'b0000;
    repeat (300) tick();
    checks++;
    if (FRAME_CNT !== 16'd0 || SER_READY !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got cnt=%0d rdy=%b required 0 0", FRAME_CNT, SER_READY);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_abort();
    test_write_commit();
    test_watchdog();
    test_reset_mid_send();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
